huffman_buffer_scheduler: RTL and testbench

HUFFMAN_BUFFER_SCHEDULER -- requirements
Module: huffman_buffer_scheduler

---
 rtl/huff_sched_pkg.sv | 16 +
 rtl/huff_sched_ring.sv | 60 ++++++
 rtl/huffman_buffer_scheduler.sv | 130 +++++++++++++
 tb/tb_huffman_buffer_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/huff_sched_pkg.sv
// Shared types and constants for the Huffman buffer scheduler.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package huff_sched_pkg;

    localparam int DEFAULT_NUM_BUFS = 4;
    localparam int DEFAULT_PTR_W    = $clog2(DEFAULT_NUM_BUFS);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } sched_state_t;

endpackage

// File: rtl/huff_sched_ring.sv
// Ring of coefficient buffers: write/read pointers plus full-buffer count.
// Latency: pointer and count updates are visible one cycle after push/pop.
// Backpressure: push is refused when all buffers are full (ready_o low, reject_o pulses).
module huff_sched_ring
    import huff_sched_pkg::*;
#(
    parameter int NUM_BUFS = DEFAULT_NUM_BUFS,
    parameter int PTR_W    = $clog2(NUM_BUFS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    output logic [PTR_W-1:0] wp_o,
    output logic [PTR_W-1:0] rp_o,
    output logic [PTR_W:0]   count_o,
    output logic             ready_o,
    output logic             reject_o
);

    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wp_q, wp_d;
    logic [PTR_W-1:0] rp_q, rp_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_acc;

    assign ready_o  = (count_q < CNT_W'(NUM_BUFS));
    assign push_acc = push_i & ready_o;
    assign reject_o = push_i & ~ready_o;
    assign wp_o     = wp_q;
    assign rp_o     = rp_q;
    assign count_o  = count_q;

    // Next pointers wrap naturally since NUM_BUFS is a power of two; push and pop together leave count alone.
    always_comb begin
        wp_d    = push_acc ? (wp_q + PTR_W'(1)) : wp_q;
        rp_d    = pop_i ? (rp_q + PTR_W'(1)) : rp_q;
        count_d = count_q;
        case ({push_acc, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/huffman_buffer_scheduler.sv
// Hands filled coefficient buffers to the Huffman encoder in ring order, one job at a time.
// Latency: fill_done into an empty idle scheduler gives huff_start two cycles later; one idle cycle between jobs.
// Backpressure: fill_ready drops when every buffer is full; a fill_done then is dropped and flags error.
// Option: define HUFF_SCHED_OVERFLOW_COUNT_EN to add an 8-bit saturating count of rejected fills.
module huffman_buffer_scheduler
    import huff_sched_pkg::*;
#(
    parameter int NUM_BUFS      = DEFAULT_NUM_BUFS,
    parameter int START_TIMEOUT = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        fill_done,
    output logic [$clog2(NUM_BUFS)-1:0] fill_buf,
    output logic                        fill_ready,
    output logic                        huff_start,
    output logic [$clog2(NUM_BUFS)-1:0] huff_buf,
    input  logic                        huff_busy,
    output logic [$clog2(NUM_BUFS):0]   occupancy,
    output logic                        idle,
    output logic                        error
`ifdef HUFF_SCHED_OVERFLOW_COUNT_EN
    ,
    output logic [7:0]                  overflow_count
`endif
);

    localparam int PTR_W = $clog2(NUM_BUFS);
    localparam int TMR_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(START_TIMEOUT - 1);

    sched_state_t     state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             error_q, error_d;
    logic             release_buf;
    logic             timeout;
    logic             reject;
    logic [PTR_W:0]   count;

    huff_sched_ring #(
        .NUM_BUFS (NUM_BUFS),
        .PTR_W    (PTR_W)
    ) u_ring (
        .clock    (clock),
        .reset    (reset),
        .push_i   (fill_done),
        .pop_i    (release_buf),
        .wp_o     (fill_buf),
        .rp_o     (huff_buf),
        .count_o  (count),
        .ready_o  (fill_ready),
        .reject_o (reject)
    );

    assign occupancy  = count;
    assign huff_start = (state_q == ST_START);
    assign idle       = (state_q == ST_IDLE) && (count == '0);
    assign error      = error_q;

    // Job sequencing: start pulse, wait for the encoder to go busy (bounded), then wait for it to finish.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        release_buf = 1'b0;
        timeout     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count != '0) state_d = ST_START;
            end
            ST_START: begin
                timer_d = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (huff_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (timer_q == TMR_LAST) begin
                    // Encoder never acknowledged: drop the buffer so the ring keeps moving.
                    timeout     = 1'b1;
                    release_buf = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!huff_busy) begin
                    release_buf = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        error_d = error_q | reject | timeout;
    end

    // FSM, timeout timer and sticky error registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            error_q <= error_d;
        end
    end

`ifdef HUFF_SCHED_OVERFLOW_COUNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    assign overflow_count = ovf_cnt_q;

    // Saturating count of rejected fills.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (reject && (ovf_cnt_q != 8'hFF)) ovf_cnt_d = ovf_cnt_q + 8'd1;
    end

    // Rejected-fill counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) ovf_cnt_q <= '0;
        else       ovf_cnt_q <= ovf_cnt_d;
    end
`else
    // Without the counter, a rejected fill is visible only through the sticky error flag.
`endif

endmodule

// File: tb/tb_huffman_buffer_scheduler.sv
// Bench for huffman_buffer_scheduler: cycle-exact vector tables plus a buffer-order scoreboard.
// Latency: vectors are checked 1 time unit after each rising edge.
// Backpressure: the table plays the encoder's huff_busy directly.
module tb_huffman_buffer_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       fill_done = 1'b0;
    logic       huff_busy = 1'b0;
    logic [1:0] fill_buf;
    logic       fill_ready;
    logic       huff_start;
    logic [1:0] huff_buf;
    logic [2:0] occupancy;
    logic       idle;
    logic       error;
`ifdef HUFF_SCHED_OVERFLOW_COUNT_EN
    logic [7:0] overflow_count;
`endif

    huffman_buffer_scheduler #(
        .NUM_BUFS      (4),
        .START_TIMEOUT (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .fill_done  (fill_done),
        .fill_buf   (fill_buf),
        .fill_ready (fill_ready),
        .huff_start (huff_start),
        .huff_buf   (huff_buf),
        .huff_busy  (huff_busy),
        .occupancy  (occupancy),
        .idle       (idle),
        .error      (error)
`ifdef HUFF_SCHED_OVERFLOW_COUNT_EN
        ,
        .overflow_count (overflow_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       fill;
        logic       busy;
        int         reps;
        logic       acc;
        logic       e_start;
        logic [1:0] e_hb;
        logic [1:0] e_fb;
        logic [2:0] e_occ;
        logic       e_rdy;
        logic       e_idle;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];
    int   sb_q[$];
    int   sb_wp = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    function automatic vec_t mk(input logic f, input logic b, input int n, input logic a,
                                input logic st, input logic [1:0] hb, input logic [1:0] fb,
                                input logic [2:0] oc, input logic rd, input logic id, input logic er);
        vec_t v;
        v.fill = f; v.busy = b; v.reps = n; v.acc = a;
        v.e_start = st; v.e_hb = hb; v.e_fb = fb; v.e_occ = oc;
        v.e_rdy = rd; v.e_idle = id; v.e_err = er;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " huff_start"}, huff_start, 0);
        chk({tag, " huff_buf"},   huff_buf,   0);
        chk({tag, " fill_buf"},   fill_buf,   0);
        chk({tag, " occupancy"},  occupancy,  0);
        chk({tag, " fill_ready"}, fill_ready, 1);
        chk({tag, " idle"},       idle,       1);
        chk({tag, " error"},      error,      0);
`ifdef HUFF_SCHED_OVERFLOW_COUNT_EN
        chk({tag, " overflow_count"}, overflow_count, 0);
`endif
    endtask

    task automatic sb_clear();
        sb_q.delete();
        sb_wp = 0;
    endtask

    task automatic do_reset(input string tag);
        fill_done = 1'b0;
        huff_busy = 1'b0;
        #2;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk_reset_vals(tag);
        reset = 1'b0;
        sb_clear();
    endtask

    // Apply table entries [lo, hi); each entry is held for reps cycles and checked after every edge.
    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                string nm;
                fill_done = tbl[i].fill;
                huff_busy = tbl[i].busy;
                if (tbl[i].acc && r == 0) begin
                    sb_q.push_back(sb_wp);
                    sb_wp = (sb_wp + 1) % 4;
                end
                @(posedge clock);
                #1;
                nm = $sformatf("v%0d.%0d", i, r);
                chk({nm, " huff_start"}, huff_start, tbl[i].e_start);
                chk({nm, " huff_buf"},   huff_buf,   tbl[i].e_hb);
                chk({nm, " fill_buf"},   fill_buf,   tbl[i].e_fb);
                chk({nm, " occupancy"},  occupancy,  tbl[i].e_occ);
                chk({nm, " fill_ready"}, fill_ready, tbl[i].e_rdy);
                chk({nm, " idle"},       idle,       tbl[i].e_idle);
                chk({nm, " error"},      error,      tbl[i].e_err);
                if (huff_start) begin
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL %s sb_order: huff_start with huff_buf=%0d but no buffer pending", nm, huff_buf);
                    end else begin
                        chk({nm, " sb_order"}, huff_buf, sb_q.pop_front());
                    end
                end
            end
        end
        fill_done = 1'b0;
    endtask

    int a_end, b_end, c_end;

    initial begin
        // Segment A: single buffer, encoder busy for 70 cycles.
        //             f  b  n  a   st hb fb oc rd id er
        tbl.push_back(mk(1, 0, 1, 1,  0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0,  1, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0,  0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0,  0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 69, 0, 0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0,  0, 1, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 2, 0,  0, 1, 1, 0, 1, 1, 0));
        a_end = tbl.size();
        // Segment B: four fills, a rejected fifth, jobs 0..3, fill coincident with release.
        tbl.push_back(mk(1, 0, 1, 1,  0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1,  1, 0, 2, 2, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1,  0, 0, 3, 3, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1,  0, 0, 0, 4, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0,  0, 0, 0, 4, 0, 0, 1));
        tbl.push_back(mk(0, 1, 3, 0,  0, 0, 0, 4, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0,  0, 1, 0, 3, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0,  1, 1, 0, 3, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0,  0, 1, 0, 3, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0,  0, 1, 0, 3, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0,  0, 2, 0, 2, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0,  1, 2, 0, 2, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0,  0, 2, 0, 2, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0,  0, 2, 0, 2, 1, 0, 1));
        tbl.push_back(mk(1, 0, 1, 1,  0, 3, 1, 2, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0,  1, 3, 1, 2, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0,  0, 3, 1, 2, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0,  0, 3, 1, 2, 1, 0, 1));
        b_end = tbl.size();
        // Segment C: after a mid-job reset with the encoder still busy, then a start timeout.
        tbl.push_back(mk(1, 1, 1, 1,  0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0,  1, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0,  0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 7, 0,  0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0,  0, 1, 1, 0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 2, 0,  0, 1, 1, 0, 1, 1, 1));
        c_end = tbl.size();

        do_reset("reset0");
        run_vecs(0, a_end);

        do_reset("reset1");
        run_vecs(a_end, b_end);
`ifdef HUFF_SCHED_OVERFLOW_COUNT_EN
        chk("overflow_count after rejected fill", overflow_count, 1);
`endif

        // Reset asserted mid-cycle while the encoder is busy in WAIT_DONE.
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("mid_job_reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        sb_clear();

        run_vecs(b_end, c_end);
        chk("scoreboard drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
